// File: rtl/multiplicador_secuencial_pkg.sv
// Shared widths, iteration count and FSM encoding for the sequential
// multiplier. Widths match the pipelined divider's operand/result sizes.
package multiplicador_secuencial_pkg;

  // Divider widths: divisor, dividend, quotient
  localparam int unsigned DV_LEN = 16;
  localparam int unsigned DD_LEN = 32;
  localparam int unsigned Q_LEN  = 16;

  // One add-shift step per multiplier bit
  localparam int unsigned MUL_ITERS = 16;

  typedef enum logic [2:0] {
    MUL_IDLE = 3'd0,
    MUL_LOAD = 3'd1,
    MUL_ITER = 3'd2,
    MUL_SIGN = 3'd3,
    MUL_FIN  = 3'd4
  } mulState_e;

endpackage

// File: rtl/multiplicador_secuencial_etapa.sv
// One combinational add-shift step of the unsigned magnitude multiplier.
// The accumulator low half lives in the multiplier register, so the
// {carry, accHi, mplier} chain shifts right as one value.
module multiplicador_etapa #(
  parameter int unsigned MLEN = 16
) (
  input  logic [MLEN-1:0] accHi,
  input  logic [MLEN-1:0] mplier,
  input  logic [MLEN-1:0] mcand,
  output logic [MLEN-1:0] nextAccHi,
  output logic [MLEN-1:0] nextMplier
);

  logic [MLEN:0] sum;

  // Conditional add into the high half keeping the carry, then shift right
  always_comb begin
    sum = {1'b0, accHi};
    if (mplier[0]) begin
      sum = sum + {1'b0, mcand};
    end
    nextAccHi  = sum[MLEN:1];
    nextMplier = {sum[0], mplier[MLEN-1:1]};
  end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Signed MLEN x MLEN -> PLEN sequential shift-add multiplier with go/done
// handshake. Works on magnitudes and applies the sign at the end, giving a
// fixed latency of LOAD + 16 ITER + SIGN + FIN.
module multiplicador_secuencial
  import multiplicador_secuencial_pkg::*;
#(
  parameter int unsigned MLEN = DV_LEN,
  parameter int unsigned PLEN = DD_LEN
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            go,
  input  logic [MLEN-1:0] mcandInput,
  input  logic [MLEN-1:0] mplierInput,
  output logic [PLEN-1:0] product,
  output logic            done,
  output logic            busy
);

  localparam int unsigned CW = $clog2(MUL_ITERS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_ITERS - 1);

  mulState_e state, nextState;

  logic [MLEN-1:0] mcandReg;
  logic [MLEN-1:0] mplierReg;
  logic [MLEN-1:0] accHi;
  logic [MLEN-1:0] nextAccHi;
  logic [MLEN-1:0] nextMplier;
  logic [CW-1:0]   count;
  logic            negRes;
  logic [PLEN-1:0] acc;

  // Low half of the accumulator has shifted into the multiplier register
  assign acc = {accHi, mplierReg};

  multiplicador_etapa #(
    .MLEN(MLEN)
  ) uEtapa (
    .accHi     (accHi),
    .mplier    (mplierReg),
    .mcand     (mcandReg),
    .nextAccHi (nextAccHi),
    .nextMplier(nextMplier)
  );

  // State register
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state <= MUL_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      MUL_IDLE: if (go) nextState = MUL_LOAD;
      MUL_LOAD: nextState = MUL_ITER;
      MUL_ITER: if (count == LAST_COUNT) nextState = MUL_SIGN;
      MUL_SIGN: nextState = MUL_FIN;
      MUL_FIN:  nextState = MUL_IDLE;
      default:  nextState = MUL_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      mcandReg  <= '0;
      mplierReg <= '0;
      accHi     <= '0;
      count     <= '0;
      negRes    <= 1'b0;
      product   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MUL_IDLE: begin
          busy <= go;
          if (go) begin
            mcandReg  <= mcandInput;
            mplierReg <= mplierInput;
          end
        end
        MUL_LOAD: begin
          mcandReg  <= mcandReg[MLEN-1]  ? (~mcandReg + 1'b1)  : mcandReg;
          mplierReg <= mplierReg[MLEN-1] ? (~mplierReg + 1'b1) : mplierReg;
          negRes    <= (mcandReg[MLEN-1] ^ mplierReg[MLEN-1]) &
                       (|mcandReg) & (|mplierReg);
          accHi     <= '0;
          count     <= '0;
        end
        MUL_ITER: begin
          accHi     <= nextAccHi;
          mplierReg <= nextMplier;
          count     <= count + 1'b1;
        end
        MUL_SIGN: begin
          product <= negRes ? (~acc + 1'b1) : acc;
        end
        MUL_FIN: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for the sequential multiplier: latency, signs, extremes,
// continuous go, mid-operation reset and a divider round trip.
module tb_multiplicador_secuencial;

  logic        reloj;
  logic        reset;
  logic        go;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [31:0] product;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  multiplicador_secuencial #(
    .MLEN(16),
    .PLEN(32)
  ) dut (
    .reloj      (reloj),
    .reset      (reset),
    .go         (go),
    .mcandInput (mcand),
    .mplierInput(mplier),
    .product    (product),
    .done       (done),
    .busy       (busy)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation; report product, latency in edges and busy after accept
  task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] res, output int lat, output logic busyAcc);
    @(negedge reloj);
    mcand  = a;
    mplier = b;
    go     = 1'b1;
    @(posedge reloj);
    #1;
    go      = 1'b0;
    busyAcc = busy;
    mcand   = 16'($urandom);
    mplier  = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge reloj);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = product;
  endtask

  logic [31:0] res;
  int          lat;
  logic        busyAcc;
  int          doneCount;
  int          acceptEdge;
  int          ea, eb, q, d, absd, r;
  longint      dividend, expRt;
  logic [15:0] t16;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    go       = 1'b0;
    mcand    = '0;
    mplier   = '0;

    // Reset state
    repeat (3) @(posedge reloj);
    #1;
    chk("rst_product", product, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge reloj);
    reset = 1'b1;

    // 1: basic latency and handshake
    runOp(16'd3, 16'd5, res, lat, busyAcc);
    chk("t1_busy_after_go", {31'd0, busyAcc}, 32'd1);
    chk("t1_latency", lat, 32'd19);
    chk("t1_product", res, 32'd15);
    @(posedge reloj);
    #1;
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_done_low", {31'd0, done}, 32'd0);

    // 2: sign combinations
    runOp(-16'sd7, 16'sd6, res, lat, busyAcc);
    chk("t2_m7x6", res, 32'hFFFF_FFD6);
    runOp(16'sd6, -16'sd7, res, lat, busyAcc);
    chk("t2_6xm7", res, 32'hFFFF_FFD6);
    runOp(-16'sd7, -16'sd6, res, lat, busyAcc);
    chk("t2_m7xm6", res, 32'd42);

    // 3: extremes and zero
    runOp(16'h8000, 16'h8000, res, lat, busyAcc);
    chk("t3_min_x_min", res, 32'h4000_0000);
    runOp(16'h8000, 16'h7FFF, res, lat, busyAcc);
    chk("t3_min_x_max", res, 32'hC000_8000);
    runOp(16'd0, 16'hFFFF, res, lat, busyAcc);
    chk("t3_zero_x_m1", res, 32'd0);
    chk("t3_zero_latency", lat, 32'd19);
    runOp(16'h7FFF, 16'h7FFF, res, lat, busyAcc);
    chk("t3_max_x_max", res, 32'h3FFF_0001);

    // 4: go held high with operands changing every cycle
    doneCount = 0;
    for (int c = 0; c <= 60; c++) begin
      @(negedge reloj);
      go     = 1'b1;
      mcand  = 16'(c * 37 - 500);
      mplier = 16'(200 - c * 13);
      @(posedge reloj);
      #1;
      if (done) begin
        doneCount++;
        acceptEdge = c - 19;
        ea = acceptEdge * 37 - 500;
        eb = 200 - acceptEdge * 13;
        chk("t4_done_edge", c, 32'(20 * doneCount - 1));
        chk("t4_product", product, 32'(ea * eb));
      end
    end
    @(negedge reloj);
    go = 1'b0;
    chk("t4_done_count", doneCount, 32'd3);
    repeat (25) @(posedge reloj);

    // 5: reset while in ITER with count=7
    @(negedge reloj);
    mcand  = 16'd9;
    mplier = 16'd9;
    go     = 1'b1;
    @(posedge reloj);
    #1;
    go = 1'b0;
    repeat (8) @(posedge reloj);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_product", product, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge reloj);
    reset = 1'b1;
    runOp(16'd2, 16'd2, res, lat, busyAcc);
    chk("t5_latency", lat, 32'd19);
    chk("t5_product", res, 32'd4);

    // 6: divider round trip; zero divisors are never sent
    for (int i = 0; i < 100; i++) begin
      t16 = 16'($urandom);
      q = int'($signed(t16));
      if (i % 10 == 0) begin
        d = 0;
      end else begin
        t16 = 16'($urandom);
        d = int'($signed(t16));
        if (d == 0) d = 1;
      end
      if (d == 0) begin
        repeat (3) @(posedge reloj);
        #1;
        chk("t6_div0_idle", {31'd0, busy}, 32'd0);
      end else begin
        absd = (d < 0) ? -d : d;
        r = int'($urandom_range(absd - 1, 0));
        if (longint'(q) * longint'(d) < 0) r = -r;
        dividend = longint'(q) * longint'(d) + longint'(r);
        expRt = dividend - longint'(r);
        runOp(16'(q), 16'(d), res, lat, busyAcc);
        chk("t6_roundtrip", res, 32'(expRt));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
